pu_master_spi_sequencer: RTL and testbench
==========================================

// Module: pu_master_spi_sequencer
// PURPOSE
//   Sequences a multi-word transaction over the byte-level SPI master driver inside pu_master_spi.
//   Buffers up to BUF_SIZE NITTA words written during a cycle.
//   On signal_cycle it asserts cs_n and splits each word into SPI bytes, MSB first.
//   It hands every byte to the driver, reassembles the received bytes into an rx buffer,
//   then releases cs_n and pulses flag_stop.
// PARAMETERS
//   DATA_WIDTH      32  NITTA word width; must be a multiple of SPI_DATA_WIDTH
//   SPI_DATA_WIDTH  8   driver byte width
//   BUF_SIZE        6   depth of the tx buffer and of the rx buffer, in words
//   CS_SETUP        2   idle cycles between cs_n fall and first drv_start (>=1)
//   CS_HOLD         2   idle cycles between last drv_ready and cs_n rise (>=1)
// PORTS
//   clk           in   1               system clock, rising edge
//   rst           in   1               asynchronous reset, active-high
//   signal_cycle  in   1               NITTA cycle boundary; launches transaction
//   tx_wr         in   1               push tx_data into tx buffer
//   tx_data       in   DATA_WIDTH      word to transmit
//   rx_oe         in   1               pop rx buffer
//   rx_data       out  DATA_WIDTH      word at rx read pointer (combinational from buffer)
//   busy          out  1               transaction in progress
//   flag_stop     out  1               1-cycle pulse, transaction finished
//   cs_n          out  1               SPI chip select, active-low
//   drv_start     out  1               1-cycle pulse: driver sends drv_tx
//   drv_tx        out  SPI_DATA_WIDTH  byte to driver, stable from drv_start to drv_ready
//   drv_rx        in   SPI_DATA_WIDTH  byte received by driver, valid with drv_ready
//   drv_ready     in   1               1-cycle pulse: driver finished the byte
// BEHAVIOUR
//   Reset (async, all outputs): cs_n=1, busy=0, flag_stop=0, drv_start=0, drv_tx=0.
//     Reset also sets rx_data=0 and clears all pointers and counts. Buffer contents are don't-care.
//   B = DATA_WIDTH/SPI_DATA_WIDTH bytes per word; N = tx count latched at launch.
//   FSM: IDLE -> SETUP -> SEND -> WAIT -> (SEND | HOLD) -> DONE -> IDLE.
//   IDLE: signal_cycle=1 and N>0 -> SETUP; next cycle cs_n=0 and busy=1.
//     The rx buffer is cleared (wptr=rptr=0) on launch.
//   SETUP: wait CS_SETUP cycles -> SEND.
//   SEND: drv_start=1 for exactly one cycle; drv_tx = byte k of word j, MSB first -> WAIT.
//   WAIT: hold drv_tx until drv_ready. Shift drv_rx into the assembly register, MSB first.
//     After byte B-1, write the assembled word to rx[j].
//     If more bytes remain -> SEND on the next cycle (one idle cycle per byte); otherwise -> HOLD.
//   HOLD: CS_HOLD cycles -> DONE. DONE: cs_n=1, busy=0, flag_stop=1 for one cycle.
//     The tx buffer is emptied (count=0) -> IDLE.
//   signal_cycle with N=0: no SPI activity, cs_n stays 1; flag_stop pulses the next cycle.
//   signal_cycle while busy: ignored (no queueing).
//   tx_wr while busy, or when tx count==BUF_SIZE: word dropped, count unchanged.
//   tx_wr and signal_cycle in the same IDLE cycle: the word is stored.
//     It is not part of this transaction's N and remains for the next cycle.
//   rx_oe: rptr advances if rptr<rx count; at rptr==rx count rx_data=0 and rptr holds.
//     rx_oe while busy is allowed and reads already-completed words only.
//   drv_ready outside WAIT: ignored.
//   Reset mid-transaction: cs_n=1 immediately (async), FSM -> IDLE, no flag_stop pulse.
// STRUCTURE
//   Shared package holds the FSM state encoding (IDLE, SETUP, SEND, WAIT, HOLD, DONE).
//   It also holds a bytes_per_word/clog2 helper reused by pu_master_spi.
//   One natural sub-module: pu_master_spi_word_buf (BUF_SIZE x DATA_WIDTH, push/pop/clear, count).
//   It is instantiated twice, once for tx and once for rx.
//   Sequencer top: FSM, byte/word counters, setup/hold timer, rx shift register. Target is ~250 lines.
// TESTING (loopback driver model: drv_rx = drv_tx ^ 8'hFF, drv_ready 5 cycles after drv_start)
//   1. Write 32'h11223344, 32'hA5A55A5A; signal_cycle.
//      -> cs_n falls 1 cycle later; 8 drv_start pulses with bytes 11,22,33,44,A5,A5,5A,5A.
//      -> rx reads EEDDCCBB, 5A5AA5A5; one flag_stop pulse.
//   2. signal_cycle with empty tx -> no drv_start, cs_n stays 1, flag_stop pulses exactly once the next cycle.
//   3. Write 7 words -> only the first 6 are sent (24 bytes); the 7th is dropped.
//      signal_cycle again mid-transfer -> ignored, no second flag_stop.
//   4. Assert rst at the 3rd drv_start -> cs_n=1 the same cycle, busy=0, no flag_stop.
//      Then 1 word + signal_cycle -> normal 4-byte transfer.
//   5. Check timing: cs_n fall to first drv_start = CS_SETUP+1 cycles.
//      Check timing: last drv_ready to cs_n rise = CS_HOLD+2 cycles.
//      Check that drv_tx is stable throughout WAIT.
//   6. 2-word transfer; rx_oe 3 times after flag_stop -> word0, word1, then 0.
//      tx_wr in the launch cycle -> that word is sent in the following transaction.

Source files
------------

// File: rtl/pu_master_spi_sequencer_pkg.sv
// Shared definitions for the pu_master_spi sequencer: FSM encoding and
// width helpers that the byte-level driver side reuses as well.
package pu_master_spi_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } seq_state_t;

  function automatic int bytes_per_word(input int data_width, input int spi_data_width);
    return data_width / spi_data_width;
  endfunction

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/pu_master_spi_word_buf.sv
// Linear word buffer: push appends, pop advances the read pointer, clear
// rewinds both pointers (a push in the same cycle lands at index 0).
module pu_master_spi_word_buf
  import pu_master_spi_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 6,
  parameter int CW         = clog2_min1(BUF_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count
);

  localparam logic [CW-1:0] SIZE_C = CW'(BUF_SIZE);

  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];
  logic [CW-1:0]         wptr_reg;
  logic [CW-1:0]         rptr_reg;
  logic                  wr_en;
  logic [CW-1:0]         wr_addr;

  assign wr_en   = push && (clear || (wptr_reg != SIZE_C));
  assign wr_addr = clear ? '0 : wptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (clear) begin
      wptr_reg <= push ? CW'(1) : '0;
      rptr_reg <= '0;
    end else begin
      if (wr_en) wptr_reg <= wptr_reg + CW'(1);
      if (pop && (rptr_reg < wptr_reg)) rptr_reg <= rptr_reg + CW'(1);
    end
  end

  // Reads past the written region return zero rather than stale contents.
  assign count   = wptr_reg;
  assign rd_data = (rptr_reg < wptr_reg) ? mem[rptr_reg] : '0;

endmodule

// File: rtl/pu_master_spi_sequencer.sv
// Multi-word SPI transaction sequencer: buffers NITTA words, streams them as
// MSB-first bytes through the byte driver under one cs_n window, collects rx.
module pu_master_spi_sequencer
  import pu_master_spi_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int BUF_SIZE       = 6,
  parameter int CS_SETUP       = 2,
  parameter int CS_HOLD        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signal_cycle,
  input  logic                      tx_wr,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      rx_oe,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      busy,
  output logic                      flag_stop,
  output logic                      cs_n,
  output logic                      drv_start,
  output logic [SPI_DATA_WIDTH-1:0] drv_tx,
  input  logic [SPI_DATA_WIDTH-1:0] drv_rx,
  input  logic                      drv_ready
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam int CW  = clog2_min1(BUF_SIZE + 1);
  localparam int BCW = clog2_min1(BPW);
  localparam int TCW = clog2_min1((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);

  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(BPW - 1);
  localparam logic [TCW-1:0] SETUP_LAST = TCW'(CS_SETUP - 1);
  localparam logic [TCW-1:0] HOLD_LAST  = TCW'(CS_HOLD - 1);
  localparam logic [CW-1:0]  SIZE_C     = CW'(BUF_SIZE);

  seq_state_t                state_reg;
  logic [CW-1:0]             n_reg;
  logic [BCW-1:0]            byte_cnt_reg;
  logic [TCW-1:0]            timer_reg;
  logic [DATA_WIDTH-1:0]     asm_reg;
  logic [DATA_WIDTH-1:0]     asm_next;
  logic                      pend_valid_reg;
  logic [DATA_WIDTH-1:0]     pend_data_reg;

  logic [DATA_WIDTH-1:0]     tx_word;
  logic [DATA_WIDTH-1:0]     tx_push_data;
  logic [CW-1:0]             tx_count;
  logic [CW-1:0]             rx_count;
  logic                      tx_full;
  logic                      launch;
  logic                      last_byte;
  logic                      last_word;
  logic                      tx_push;
  logic                      tx_pop;
  logic                      tx_clear;
  logic                      rx_push;
  logic [SPI_DATA_WIDTH-1:0] tx_bytes [BPW];

  for (genvar gi = 0; gi < BPW; gi++) begin : g_byte
    assign tx_bytes[gi] = tx_word[DATA_WIDTH-1-gi*SPI_DATA_WIDTH -: SPI_DATA_WIDTH];
  end

  assign tx_full   = (tx_count == SIZE_C);
  assign launch    = (state_reg == ST_IDLE) && signal_cycle && (tx_count != '0);
  assign last_byte = (byte_cnt_reg == BYTE_LAST);
  // rx_count is the number of words already completed, i.e. the current word index.
  assign last_word = (rx_count == (n_reg - CW'(1)));
  assign asm_next  = DATA_WIDTH'({asm_reg, drv_rx});

  // A word written in the launch cycle is parked and re-pushed once the buffer is emptied.
  assign tx_push      = ((state_reg == ST_IDLE) && tx_wr && !launch) ||
                        ((state_reg == ST_DONE) && pend_valid_reg);
  assign tx_push_data = (state_reg == ST_DONE) ? pend_data_reg : tx_data;
  assign tx_pop       = (state_reg == ST_SEND) && last_byte;
  assign tx_clear     = (state_reg == ST_DONE);
  assign rx_push      = (state_reg == ST_WAIT) && drv_ready && last_byte;

  pu_master_spi_word_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_SIZE   (BUF_SIZE),
    .CW         (CW)
  ) u_tx_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .clear     (tx_clear),
    .rd_data   (tx_word),
    .count     (tx_count)
  );

  pu_master_spi_word_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_SIZE   (BUF_SIZE),
    .CW         (CW)
  ) u_rx_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (asm_next),
    .pop       (rx_oe),
    .clear     (launch),
    .rd_data   (rx_data),
    .count     (rx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cs_n           <= 1'b1;
      busy           <= 1'b0;
      flag_stop      <= 1'b0;
      drv_start      <= 1'b0;
      drv_tx         <= '0;
      n_reg          <= '0;
      byte_cnt_reg   <= '0;
      timer_reg      <= '0;
      asm_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
    end else begin
      flag_stop <= 1'b0;
      drv_start <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            state_reg      <= ST_SETUP;
            cs_n           <= 1'b0;
            busy           <= 1'b1;
            n_reg          <= tx_count;
            byte_cnt_reg   <= '0;
            timer_reg      <= '0;
            pend_valid_reg <= tx_wr && !tx_full;
            pend_data_reg  <= tx_data;
          end else if (signal_cycle) begin
            flag_stop <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (timer_reg == SETUP_LAST) state_reg <= ST_SEND;
          else                         timer_reg <= timer_reg + TCW'(1);
        end
        ST_SEND: begin
          drv_start <= 1'b1;
          drv_tx    <= tx_bytes[byte_cnt_reg];
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drv_ready) begin
            asm_reg <= asm_next;
            if (!last_byte) begin
              byte_cnt_reg <= byte_cnt_reg + BCW'(1);
              state_reg    <= ST_SEND;
            end else begin
              byte_cnt_reg <= '0;
              if (last_word) begin
                timer_reg <= '0;
                state_reg <= ST_HOLD;
              end else begin
                state_reg <= ST_SEND;
              end
            end
          end
        end
        ST_HOLD: begin
          if (timer_reg == HOLD_LAST) state_reg <= ST_DONE;
          else                        timer_reg <= timer_reg + TCW'(1);
        end
        ST_DONE: begin
          cs_n           <= 1'b1;
          busy           <= 1'b0;
          flag_stop      <= 1'b1;
          pend_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_master_spi_sequencer.sv
// Bench for pu_master_spi_sequencer with a loopback byte driver
// (rx = tx ^ FF, ready 5 cycles after start) and a word-queue reference model.
module tb_pu_master_spi_sequencer;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        signal_cycle;
  logic        tx_wr;
  logic [31:0] tx_data;
  logic        rx_oe;
  logic [31:0] rx_data;
  logic        busy;
  logic        flag_stop;
  logic        cs_n;
  logic        drv_start;
  logic [7:0]  drv_tx;
  logic [7:0]  drv_rx = 8'h00;
  logic        drv_ready;
  logic        mdl_rdy = 1'b0;
  logic        spur = 1'b0;

  assign drv_ready = mdl_rdy | spur;

  always #5 clk = ~clk;

  pu_master_spi_sequencer #(
    .DATA_WIDTH     (32),
    .SPI_DATA_WIDTH (8),
    .BUF_SIZE       (6),
    .CS_SETUP       (CS_SETUP),
    .CS_HOLD        (CS_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signal_cycle (signal_cycle),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .rx_oe        (rx_oe),
    .rx_data      (rx_data),
    .busy         (busy),
    .flag_stop    (flag_stop),
    .cs_n         (cs_n),
    .drv_start    (drv_start),
    .drv_tx       (drv_tx),
    .drv_rx       (drv_rx),
    .drv_ready    (drv_ready)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Driver model and monitor, both sampled mid-cycle.
  int         cyc = 0;
  int         rdy_cnt = 0;
  logic [7:0] sent_q[$];
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         csn_fall_cnt = 0;
  int         csn_fall_cyc = 0;
  int         csn_rise_cyc = 0;
  int         first_start_cyc = 0;
  int         last_rdy_cyc = 0;
  bit         first_seen = 1'b0;
  bit         in_wait = 1'b0;
  bit         stable = 1'b1;
  logic [7:0] hold_tx = 8'h00;
  logic       prev_csn = 1'b1;

  always @(negedge clk) begin
    cyc++;
    mdl_rdy = 1'b0;
    if (rst) begin
      rdy_cnt = 0;
      in_wait = 1'b0;
    end else begin
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) begin
          mdl_rdy = 1'b1;
          drv_rx  = drv_tx ^ 8'hFF;
        end
      end
      if (drv_start) rdy_cnt = 5;
    end
    if (prev_csn && !cs_n) begin
      csn_fall_cnt++;
      csn_fall_cyc = cyc;
      first_seen   = 1'b0;
    end
    if (!prev_csn && cs_n && !rst) csn_rise_cyc = cyc;
    prev_csn = cs_n;
    if (drv_start) begin
      sent_q.push_back(drv_tx);
      start_cnt++;
      chk("cs_low_at_start", {31'b0, cs_n}, 32'd0);
      if (!first_seen) begin
        first_seen      = 1'b1;
        first_start_cyc = cyc;
      end
      hold_tx = drv_tx;
      in_wait = 1'b1;
      stable  = 1'b1;
    end else if (in_wait && drv_tx !== hold_tx) begin
      stable = 1'b0;
    end
    if (mdl_rdy && in_wait) begin
      in_wait      = 1'b0;
      last_rdy_cyc = cyc;
      chk("drv_tx_stable", {31'b0, stable}, 32'd1);
    end
    if (flag_stop) stop_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Reference model: words the design should hold, in order.
  logic [31:0] mq[$];
  logic [31:0] rb_q[$];
  int          launch_cyc = 0;
  int          txn_no = 0;

  task automatic write_word(input logic [31:0] w);
    tx_wr   = 1'b1;
    tx_data = w;
    if (mq.size() < 6) mq.push_back(w);
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic run_txn(input int nwr, input bit lw, input int exp_sent, input bit poke);
    logic [31:0] sent[$];
    logic [31:0] pw;
    logic [31:0] w;
    bit          pend;
    int          n;
    for (int i = 0; i < nwr; i++) write_word($urandom);
    sent_q.delete();
    stop_cnt     = 0;
    csn_fall_cnt = 0;
    n    = mq.size();
    pw   = $urandom;
    pend = lw && (n < 6);
    for (int i = 0; i < n; i++) sent.push_back(mq.pop_front());
    launch_cyc   = cyc;
    signal_cycle = 1'b1;
    tx_wr        = lw;
    tx_data      = pw;
    tick();
    signal_cycle = 1'b0;
    tx_wr        = 1'b0;
    if (n == 0) begin
      chk("stop_next_cycle", stop_cnt, 1);
      if (lw) mq.push_back(pw);
      pend = 1'b0;
    end else begin
      for (int k = 0; k < 3000 && stop_cnt == 0; k++) begin
        if (poke && k == 20) begin
          signal_cycle = 1'b1;
          tx_wr        = 1'b1;
          tx_data      = $urandom;
        end
        tick();
        signal_cycle = 1'b0;
        tx_wr        = 1'b0;
      end
      chk("flag_stop_seen", {31'b0, stop_cnt != 0}, 32'd1);
    end
    repeat (8) tick();
    chk("flag_stop_once", stop_cnt, 1);
    chk("byte_count", sent_q.size(), exp_sent * 4);
    for (int b = 0; b < n * 4 && b < sent_q.size(); b++) begin
      w = sent[b / 4];
      chk("tx_byte", {24'b0, sent_q[b]}, (w >> (8 * (3 - (b % 4)))) & 32'hFF);
    end
    rb_q.delete();
    if (n == 0) begin
      chk("csn_stays_high", csn_fall_cnt, 0);
      chk("rx_empty", rx_data, 32'd0);
    end else begin
      for (int j = 0; j <= n; j++) begin
        rb_q.push_back(rx_data);
        chk("rx_word", rx_data, (j < n) ? ~sent[j] : 32'd0);
        rx_oe = 1'b1;
        tick();
        rx_oe = 1'b0;
      end
    end
    if (pend) mq.push_back(pw);
    $display("txn %0d: wrote %0d, launch_wr %0d, sent %0d words (%0d bytes), flag_stop %0d",
             txn_no, nwr, lw, n, sent_q.size(), stop_cnt);
    txn_no++;
  endtask

  typedef struct {
    int nwr;
    bit lw;
    int exp_sent;
    bit poke;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] exp_b[8];

  initial begin
    tbl[0] = '{0, 1'b0, 0, 1'b0};
    tbl[1] = '{7, 1'b0, 6, 1'b1};
    tbl[2] = '{1, 1'b1, 1, 1'b0};
    tbl[3] = '{2, 1'b0, 3, 1'b0};
    tbl[4] = '{0, 1'b1, 0, 1'b0};
    tbl[5] = '{5, 1'b1, 6, 1'b0};
    tbl[6] = '{4, 1'b0, 4, 1'b0};
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'h5A, 8'h5A};

    rst = 1'b1; signal_cycle = 1'b0; tx_wr = 1'b0; tx_data = '0; rx_oe = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_flag_stop", {31'b0, flag_stop}, 32'd0);
    chk("rst_drv_start", {31'b0, drv_start}, 32'd0);
    chk("rst_drv_tx", {24'b0, drv_tx}, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    rst = 1'b0;
    tick();

    write_word(32'h11223344);
    write_word(32'hA5A55A5A);
    run_txn(0, 1'b0, 2, 1'b0);
    for (int b = 0; b < 8 && b < sent_q.size(); b++) chk("t1_byte", {24'b0, sent_q[b]}, {24'b0, exp_b[b]});
    chk("t1_rx0", (rb_q.size() > 0) ? rb_q[0] : 32'hDEAD, 32'hEEDDCCBB);
    chk("t1_rx1", (rb_q.size() > 1) ? rb_q[1] : 32'hDEAD, 32'h5A5AA5A5);
    chk("launch_to_csn_fall", csn_fall_cyc - launch_cyc, 1);
    chk("csn_fall_to_start", first_start_cyc - csn_fall_cyc, CS_SETUP + 1);
    chk("last_ready_to_csn_rise", csn_rise_cyc - last_rdy_cyc, CS_HOLD + 2);

    start_cnt = 0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (2) tick();
    chk("spur_ready_busy", {31'b0, busy}, 32'd0);
    chk("spur_ready_start", start_cnt, 0);

    for (int v = 0; v < 7; v++) run_txn(tbl[v].nwr, tbl[v].lw, tbl[v].exp_sent, tbl[v].poke);

    for (int i = 0; i < 3; i++) write_word($urandom);
    start_cnt    = 0;
    stop_cnt     = 0;
    signal_cycle = 1'b1;
    tick();
    signal_cycle = 1'b0;
    for (int k = 0; k < 500 && start_cnt < 3; k++) tick();
    chk("reset_reached_start3", start_cnt, 3);
    rst = 1'b1;
    #1;
    chk("reset_cs_n_async", {31'b0, cs_n}, 32'd1);
    chk("reset_busy_async", {31'b0, busy}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("reset_no_flag_stop", stop_cnt, 0);
    $display("txn %0d: reset at third drv_start, flag_stop %0d", txn_no, stop_cnt);
    txn_no++;
    mq.delete();
    run_txn(1, 1'b0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
